// File: rtl/bank_queue_pkg.sv
// Shared types and width helpers for the bank queue controller.
// Contents:
//   div_state_e - wait-time divider control states
//   cnt_width   - width of the customer count
//   tel_width   - width of the teller count
//   num_width   - width of the wait-time numerator / quotient
package bank_queue_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_width(input int max_people);
        return $clog2(max_people + 1);
    endfunction

    function automatic int tel_width(input int max_tellers);
        return $clog2(max_tellers + 1);
    endfunction

    // Largest numerator is SERVICE_TIME*(MAX_PEOPLE+MAX_TELLERS-1).
    function automatic int num_width(input int service_time, input int max_people,
                                     input int max_tellers);
        return $clog2(service_time * (max_people + max_tellers - 1) + 1);
    endfunction

endpackage

// File: rtl/bank_queue_ctrl_if.sv
// Sensor, teller and status bundle of the bank queue controller.
// Signals:
//   sens_a, sens_b - entry / exit photo sensors (idle high, asynchronous)
//   tcount         - active teller count (quasi-static)
//   err_clr        - one-cycle pulse clearing the sticky errors
//   pcount, empty_flag, full_flag, ovf_err, udf_err - queue status
//   wtime, wt_valid, no_teller - wait-time estimate and its qualifiers
// Modports: slave = controller side, master = sensor/display side.
interface bank_queue_ctrl_if
    import bank_queue_pkg::*;
#(
    parameter int MAX_PEOPLE   = 7,
    parameter int MAX_TELLERS  = 3,
    parameter int SERVICE_TIME = 3
) ();
    localparam int CNT_W = cnt_width(MAX_PEOPLE);
    localparam int TEL_W = tel_width(MAX_TELLERS);
    localparam int NUM_W = num_width(SERVICE_TIME, MAX_PEOPLE, MAX_TELLERS);

    logic             sens_a;
    logic             sens_b;
    logic [TEL_W-1:0] tcount;
    logic             err_clr;
    logic [CNT_W-1:0] pcount;
    logic             empty_flag;
    logic             full_flag;
    logic             ovf_err;
    logic             udf_err;
    logic [NUM_W-1:0] wtime;
    logic             wt_valid;
    logic             no_teller;

    modport slave (
        input  sens_a, sens_b, tcount, err_clr,
        output pcount, empty_flag, full_flag, ovf_err, udf_err, wtime, wt_valid, no_teller
    );

    modport master (
        output sens_a, sens_b, tcount, err_clr,
        input  pcount, empty_flag, full_flag, ovf_err, udf_err, wtime, wt_valid, no_teller
    );
endinterface

// File: rtl/bank_queue_ctrl_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle, W cycles per divide.
// Ports:
//   clk, reset - clock, synchronous active-high reset (control only)
//   start_i    - load operands and (re)start; re-asserting aborts a divide
//   dividend_i, divisor_i - operands, sampled on start_i
//   busy_o     - a divide is in progress
//   done_o     - the final quotient bit is produced on this clock edge
//   quotient_o - quotient; final on the cycle after done_o
module seq_divider #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] quotient_o
);
    localparam int CW = $clog2(W + 1);

    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic [W:0]    rem_q,  rem_d;
    logic [W-1:0]  quo_q,  quo_d;
    logic [W-1:0]  div_q;
    logic [W+1:0]  rem_sh;
    logic [W:0]    quo_ext;
    logic          ge;

    // Shift the next dividend bit into the partial remainder and subtract if it fits.
    always_comb begin
        rem_sh  = {rem_q, quo_q[W-1]};
        ge      = (rem_sh >= {2'b00, div_q});
        rem_d   = ge ? (rem_sh[W:0] - {1'b0, div_q}) : rem_sh[W:0];
        quo_ext = {quo_q, ge};
        quo_d   = quo_ext[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            cnt_q  <= CW'(W);
        end else if (busy_q) begin
            busy_q <= (cnt_q != CW'(1));
            cnt_q  <= cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (start_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            div_q <= divisor_i;
        end else if (busy_q) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (cnt_q == CW'(1));
    assign quotient_o = quo_q;
endmodule

// File: rtl/bank_queue_ctrl.sv
// Single-queue, multi-teller customer manager.
// Counts customers from entry/exit sensor falling edges, flags empty/full,
// keeps sticky overflow/underflow errors and estimates the wait time
// wtime = SERVICE_TIME*(pcount+teff-1)/teff with a multi-cycle divider.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - bank_queue_ctrl_if.slave (sensors, tellers, status outputs)
module bank_queue_ctrl
    import bank_queue_pkg::*;
#(
    parameter int MAX_PEOPLE   = 7,
    parameter int MAX_TELLERS  = 3,
    parameter int SERVICE_TIME = 3
) (
    input  logic            clk,
    input  logic            reset,
    bank_queue_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_width(MAX_PEOPLE);
    localparam int TEL_W = tel_width(MAX_TELLERS);
    localparam int NUM_W = num_width(SERVICE_TIME, MAX_PEOPLE, MAX_TELLERS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PEOPLE);
    localparam logic [TEL_W-1:0] MAX_TEL = TEL_W'(MAX_TELLERS);

    // Sensor path, bit 0 = entry, bit 1 = exit. Preset high so reset never
    // produces a falling edge.
    logic [1:0] sens_raw, sync1_q, sync2_q, hist_q, evt;
    assign sens_raw = {bus.sens_b, bus.sens_a};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
            hist_q  <= '1;
        end else begin
            sync1_q <= sens_raw;
            sync2_q <= sync1_q;
            hist_q  <= sync2_q;
        end
    end

    assign evt = hist_q & ~sync2_q;

    // Customer count and flags
    logic [CNT_W-1:0] pcount_q, pcount_d;
    logic             empty_q, full_q, ovf_q, udf_q, ovf_d, udf_d;
    logic             ovf_set, udf_set;

    always_comb begin
        pcount_d = pcount_q;
        ovf_set  = 1'b0;
        udf_set  = 1'b0;
        case (evt)
            2'b01: begin
                if (pcount_q == MAX_CNT) ovf_set  = 1'b1;
                else                     pcount_d = pcount_q + CNT_W'(1);
            end
            2'b10: begin
                if (pcount_q == '0) udf_set  = 1'b1;
                else                pcount_d = pcount_q - CNT_W'(1);
            end
            default: ;
        endcase
        // A new error outranks a simultaneous clear.
        ovf_d = ovf_set | (ovf_q & ~bus.err_clr);
        udf_d = udf_set | (udf_q & ~bus.err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcount_q <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            pcount_q <= pcount_d;
            empty_q  <= (pcount_d == '0);
            full_q   <= (pcount_d == MAX_CNT);
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Wait-time estimate
    logic [TEL_W-1:0] teff, lat_t_q;
    logic [CNT_W-1:0] lat_p_q;
    logic [NUM_W-1:0] wtime_q, numer, divisor, quotient;
    logic             wt_valid_q, shortcut, mismatch, load, wt_write;
    logic             div_busy, div_done;
    div_state_e       state_q, state_d;

    assign teff     = (bus.tcount > MAX_TEL) ? MAX_TEL : bus.tcount;
    assign shortcut = (pcount_q == '0) || (teff == '0);
    assign mismatch = ({pcount_q, teff} != {lat_p_q, lat_t_q});
    assign numer    = NUM_W'(SERVICE_TIME * (32'(pcount_q) + 32'(teff) - 1));
    assign divisor  = NUM_W'(teff);

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Any operand change relatches and restarts, whatever the state.
    always_comb begin
        state_d = state_q;
        if (shortcut)      state_d = IDLE;
        else if (mismatch) state_d = CALC;
        else begin
            case (state_q)
                CALC:    if (div_busy && div_done) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load     = !shortcut && mismatch;
        wt_write = !shortcut && !mismatch && (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_p_q    <= '0;
            lat_t_q    <= '0;
            wtime_q    <= '0;
            wt_valid_q <= 1'b1;
        end else if (shortcut) begin
            // Track operands so a later return to them still triggers a divide.
            lat_p_q    <= pcount_q;
            lat_t_q    <= teff;
            wtime_q    <= (pcount_q == '0) ? '0 : '1;
            wt_valid_q <= 1'b1;
        end else if (load) begin
            lat_p_q    <= pcount_q;
            lat_t_q    <= teff;
            wt_valid_q <= 1'b0;
        end else if (wt_write) begin
            wtime_q    <= quotient;
            wt_valid_q <= 1'b1;
        end
    end

    seq_divider #(.W(NUM_W)) u_div (
        .clk        (clk),
        .reset      (reset),
        .start_i    (load),
        .dividend_i (numer),
        .divisor_i  (divisor),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (quotient)
    );

    assign bus.pcount     = pcount_q;
    assign bus.empty_flag = empty_q;
    assign bus.full_flag  = full_q;
    assign bus.ovf_err    = ovf_q;
    assign bus.udf_err    = udf_q;
    assign bus.wtime      = wtime_q;
    assign bus.wt_valid   = wt_valid_q;
    assign bus.no_teller  = (teff == '0);
endmodule

// File: tb/tb_bank_queue_ctrl.sv
module tb_bank_queue_ctrl;
    localparam int MAXP  = 7;
    localparam int MAXT  = 3;
    localparam int ST    = 3;
    localparam int NUM_W = $clog2(ST * (MAXP + MAXT - 1) + 1);
    localparam int SETTLE = NUM_W + 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bank_queue_ctrl_if #(.MAX_PEOPLE(MAXP), .MAX_TELLERS(MAXT), .SERVICE_TIME(ST)) bus ();

    bank_queue_ctrl #(.MAX_PEOPLE(MAXP), .MAX_TELLERS(MAXT), .SERVICE_TIME(ST)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_cnt = 0;
    int m_ovf = 0;
    int m_udf = 0;
    int m_tel = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_wtime(input int p, input int t);
        int te;
        te = (t > MAXT) ? MAXT : t;
        if (p == 0) return 0;
        if (te == 0) return (1 << NUM_W) - 1;
        return (ST * (p + te - 1)) / te;
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".pcount"},    32'(bus.pcount),     32'(m_cnt));
        chk({tag, ".empty"},     32'(bus.empty_flag), 32'(m_cnt == 0));
        chk({tag, ".full"},      32'(bus.full_flag),  32'(m_cnt == MAXP));
        chk({tag, ".ovf"},       32'(bus.ovf_err),    32'(m_ovf));
        chk({tag, ".udf"},       32'(bus.udf_err),    32'(m_udf));
        chk({tag, ".no_teller"}, 32'(bus.no_teller),  32'(m_tel == 0));
        chk({tag, ".wtime"},     32'(bus.wtime),      32'(model_wtime(m_cnt, m_tel)));
        chk({tag, ".wt_valid"},  32'(bus.wt_valid),   32'd1);
    endtask

    task automatic settle();
        repeat (SETTLE) @(negedge clk);
    endtask

    // One sensor event (entry a, exit b) with an optional err_clr aligned to the
    // cycle in which the controller applies the event.
    task automatic act(input bit a, input bit b, input bit clr);
        @(negedge clk);
        bus.sens_a = ~a;
        bus.sens_b = ~b;
        @(negedge clk);
        @(negedge clk);
        bus.sens_a = 1'b1;
        bus.sens_b = 1'b1;
        bus.err_clr = clr;
        @(negedge clk);
        bus.err_clr = 1'b0;
        if (clr) begin
            m_ovf = 0;
            m_udf = 0;
        end
        if (a && !b) begin
            if (m_cnt == MAXP) m_ovf = 1;
            else               m_cnt++;
        end else if (b && !a) begin
            if (m_cnt == 0) m_udf = 1;
            else            m_cnt--;
        end
    endtask

    task automatic clear_err();
        @(negedge clk);
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    task automatic set_tel(input int t);
        @(negedge clk);
        bus.tcount = 2'(t);
        m_tel = t;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.sens_a = 1'b1;
        bus.sens_b = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_cnt = 0;
        m_ovf = 0;
        m_udf = 0;
    endtask

    initial begin
        int lows;
        int other;
        int r;

        reset       = 1'b1;
        bus.sens_a  = 1'b1;
        bus.sens_b  = 1'b1;
        bus.err_clr = 1'b0;
        bus.tcount  = 2'd2;
        m_tel       = 2;
        repeat (2) @(negedge clk);
        check_all("reset");
        reset = 1'b0;

        // Three entries with two tellers; measure the invalid window of the last one.
        act(1, 0, 0); settle();
        act(1, 0, 0); settle();
        act(1, 0, 0);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.wt_valid) lows++;
        end
        chk("three.valid_low_cycles", 32'(lows), 32'(NUM_W + 1));
        check_all("three");

        // Overflow and clear
        do_reset();
        for (int i = 0; i < 8; i++) act(1, 0, 0);
        settle();
        check_all("overflow");
        clear_err(); settle();
        check_all("ovf_clear");

        // Underflow, then simultaneous entry/exit at 4
        do_reset();
        act(0, 1, 0); settle();
        check_all("underflow");
        clear_err();
        for (int i = 0; i < 4; i++) act(1, 0, 0);
        act(1, 1, 0); settle();
        check_all("both_at4");

        // Error set wins over a coincident clear
        act(0, 1, 1);
        act(0, 1, 1);
        act(0, 1, 1);
        act(0, 1, 1);
        act(0, 1, 1); settle();
        check_all("set_wins");

        // No teller saturation, then three tellers at pcount 5
        for (int i = 0; i < 5; i++) act(1, 0, 0);
        set_tel(0); settle();
        check_all("no_teller");
        set_tel(3); settle();
        check_all("tel3_p5");

        // Operand change two cycles into a divide
        act(0, 1, 0); settle();
        check_all("p4_tel3");
        @(negedge clk);
        bus.tcount = 2'd1;
        lows  = 0;
        other = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.wt_valid) lows++;
            if (bus.wtime != 5'(model_wtime(4, 3))) other++;
            if (i == 1) bus.tcount = 2'd3;
        end
        chk("midcalc.valid_low_cycles", 32'(lows), 32'(NUM_W + 3));
        chk("midcalc.interim_writes", 32'(other), 32'd0);
        check_all("midcalc");

        // Reset in the middle of a divide
        act(1, 0, 0);
        act(1, 0, 0); settle();
        check_all("p6");
        set_tel(2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_cnt = 0;
        m_ovf = 0;
        m_udf = 0;
        check_all("reset_midcalc");
        settle();
        check_all("post_reset");

        // Randomized operation mix
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3: act(1, 0, 0);
                4, 5:       act(0, 1, 0);
                6:          act(1, 1, 0);
                7:          clear_err();
                8:          set_tel($urandom_range(0, 3));
                default:    act(1, 0, 1);
            endcase
            settle();
            check_all($sformatf("rand%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
